// File: rtl/riscv_defines_pkg.sv
// rtl/riscv_defines_pkg.sv - shared RISC-V types: instruction word, trap request, fetch packet
package riscv_defines;

    localparam int RV_XLEN = 32;

    typedef logic [31:0] inst_t;

    // addi x0, x0, 0 -- what decode sees when the queue has nothing to offer
    localparam inst_t NOP_INST = 32'h0000_0013;

    typedef enum logic [3:0] {
        CAUSE_MISALIGNED_FETCH    = 4'd0,
        CAUSE_FETCH_ACCESS        = 4'd1,
        CAUSE_ILLEGAL_INSTRUCTION = 4'd2,
        CAUSE_BREAKPOINT          = 4'd3
    } trap_cause_t;

    typedef struct packed {
        logic               valid;
        trap_cause_t        cause;
        logic [RV_XLEN-1:0] tval;
    } trap_req_t;

    // One queue entry: everything decode needs about a fetched instruction
    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_XLEN-1:0] pcplus4;
        logic [RV_XLEN-1:0] pc_pred;
        logic               pred_taken;
        inst_t              inst;
        trap_req_t          trap_req;
    } fetch_pkt_t;

    localparam fetch_pkt_t BUBBLE_PKT = '{
        pc:         '0,
        pcplus4:    '0,
        pc_pred:    '0,
        pred_taken: 1'b0,
        inst:       NOP_INST,
        trap_req:   '0
    };

endpackage

// File: rtl/id_fetch_queue_mem.sv
// rtl/id_fetch_queue_mem.sv - DEPTH x WIDTH register array, one write port, async read port
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index
//   rdata  - read data, combinational from raddr
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents need no reset: occupancy logic never exposes an unwritten slot
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/id_fetch_queue.sv
// rtl/id_fetch_queue.sv - decoupled DEPTH-entry instruction queue between fetch and decode
//
// Ports:
//   clk, start          - clock; asynchronous active-low reset
//   valid_f / ready_f   - fetch-side handshake
//   pc_f, pcplus4_f, pc_pred_f, pred_taken_f, inst_f, trap_req_f - entry from fetch
//   flush               - discard all entries and lift the trap fence
//   valid_d / ready_d   - decode-side handshake
//   pc_d, pcplus4_d, pc_pred_d, pred_taken_d, inst_d, trap_req_d - head entry (bubble when empty)
//   count               - current occupancy
module id_fetch_queue
    import riscv_defines::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       start,
    input  logic                       valid_f,
    output logic                       ready_f,
    input  logic [XLEN-1:0]            pc_f,
    input  logic [XLEN-1:0]            pcplus4_f,
    input  logic [XLEN-1:0]            pc_pred_f,
    input  logic                       pred_taken_f,
    input  inst_t                      inst_f,
    input  trap_req_t                  trap_req_f,
    input  logic                       flush,
    output logic                       valid_d,
    input  logic                       ready_d,
    output logic [XLEN-1:0]            pc_d,
    output logic [XLEN-1:0]            pcplus4_d,
    output logic [XLEN-1:0]            pc_pred_d,
    output logic                       pred_taken_d,
    output inst_t                      inst_d,
    output trap_req_t                  trap_req_d,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $bits(fetch_pkt_t);

    // Pointers carry one extra bit so full and empty are distinguishable
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          trap_fence;
    logic [AW:0]   occ;
    logic          full;
    logic          enq;
    logic          deq;
    fetch_pkt_t    wr_pkt;
    fetch_pkt_t    rd_pkt;
    fetch_pkt_t    head;
    logic [PW-1:0] rd_data;

    assign occ     = wr_ptr - rd_ptr;
    assign full    = (occ == (AW+1)'(DEPTH));
    assign count   = occ;

    // Depends only on state, so fetch never waits on decode's ready in the same cycle
    assign ready_f = !full && !trap_fence;
    assign valid_d = (occ != '0);

    assign enq = valid_f && ready_f;
    assign deq = valid_d && ready_d;

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            trap_fence <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            trap_fence <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
                // Nothing younger than a trapping instruction may enter until redirect
                if (trap_req_f.valid) begin
                    trap_fence <= 1'b1;
                end
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign wr_pkt = '{
        pc:         pc_f,
        pcplus4:    pcplus4_f,
        pc_pred:    pc_pred_f,
        pred_taken: pred_taken_f,
        inst:       inst_f,
        trap_req:   trap_req_f
    };

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_mem (
        .clk   (clk),
        .we    (enq && !flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_pkt),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign rd_pkt = fetch_pkt_t'(rd_data);
    assign head   = valid_d ? rd_pkt : BUBBLE_PKT;

    assign pc_d         = head.pc;
    assign pcplus4_d    = head.pcplus4;
    assign pc_pred_d    = head.pc_pred;
    assign pred_taken_d = head.pred_taken;
    assign inst_d       = head.inst;
    assign trap_req_d   = head.trap_req;

endmodule

// File: tb/tb_id_fetch_queue.sv
// tb/tb_id_fetch_queue.sv - randomized and directed self-checking bench for id_fetch_queue
module tb_id_fetch_queue;
    import riscv_defines::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             start;
    logic             valid_f;
    logic             ready_f;
    logic [XLEN-1:0]  pc_f, pcplus4_f, pc_pred_f;
    logic             pred_taken_f;
    inst_t            inst_f;
    trap_req_t        trap_req_f;
    logic             flush;
    logic             valid_d;
    logic             ready_d;
    logic [XLEN-1:0]  pc_d, pcplus4_d, pc_pred_d;
    logic             pred_taken_d;
    inst_t            inst_d;
    trap_req_t        trap_req_d;
    logic [2:0]       count;

    id_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .start(start),
        .valid_f(valid_f), .ready_f(ready_f),
        .pc_f(pc_f), .pcplus4_f(pcplus4_f), .pc_pred_f(pc_pred_f),
        .pred_taken_f(pred_taken_f), .inst_f(inst_f), .trap_req_f(trap_req_f),
        .flush(flush),
        .valid_d(valid_d), .ready_d(ready_d),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d), .pc_pred_d(pc_pred_d),
        .pred_taken_d(pred_taken_d), .inst_d(inst_d), .trap_req_d(trap_req_d),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: an ordered list of accepted packets plus the fence flag
    fetch_pkt_t mq[$];
    bit         mfence;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic fetch_pkt_t mk(input logic [31:0] pc, input bit trap, input trap_cause_t cause);
        fetch_pkt_t p;
        p.pc             = pc;
        p.pcplus4        = pc + 32'd4;
        p.pc_pred        = pc ^ 32'h0000_0040;
        p.pred_taken     = pc[2];
        p.inst           = {pc[15:0], 16'h0033};
        p.trap_req.valid = trap;
        p.trap_req.cause = cause;
        p.trap_req.tval  = trap ? pc : 32'h0;
        return p;
    endfunction

    function automatic fetch_pkt_t bubble();
        fetch_pkt_t p;
        p = '0;
        p.inst = 32'h0000_0013;
        return p;
    endfunction

    task automatic check_outputs(input string tag);
        fetch_pkt_t obs, exp;
        obs = '{pc: pc_d, pcplus4: pcplus4_d, pc_pred: pc_pred_d, pred_taken: pred_taken_d,
                inst: inst_d, trap_req: trap_req_d};
        exp = (mq.size() != 0) ? mq[0] : bubble();
        chk({tag, ".valid_d"}, 192'(valid_d), 192'(mq.size() != 0));
        chk({tag, ".count"},   192'(count),   192'(mq.size()));
        chk({tag, ".ready_f"}, 192'(ready_f), 192'((mq.size() < DEPTH) && !mfence));
        chk({tag, ".head"},    192'(obs),     192'(exp));
    endtask

    // Apply one cycle of inputs, advance the model by the same rules, then check
    task automatic step(input string tag, input bit vf, input fetch_pkt_t p, input bit fl, input bit rd);
        bit acc, pop;
        valid_f      = vf;
        pc_f         = p.pc;
        pcplus4_f    = p.pcplus4;
        pc_pred_f    = p.pc_pred;
        pred_taken_f = p.pred_taken;
        inst_f       = p.inst;
        trap_req_f   = p.trap_req;
        flush        = fl;
        ready_d      = rd;
        if (fl) begin
            mq.delete();
            mfence = 0;
        end else begin
            acc = vf && (mq.size() < DEPTH) && !mfence;
            pop = rd && (mq.size() != 0);
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(p);
                if (p.trap_req.valid) mfence = 1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    fetch_pkt_t idle;

    initial begin
        idle = mk(32'h0, 0, CAUSE_MISALIGNED_FETCH);
        start = 1'b0; valid_f = 0; flush = 0; ready_d = 0;
        pc_f = '0; pcplus4_f = '0; pc_pred_f = '0; pred_taken_f = 0; inst_f = '0; trap_req_f = '0;
        mfence = 0;
        #2;
        check_outputs("reset");
        #10 start = 1'b1;
        @(posedge clk); #1;
        check_outputs("post_reset");

        // Fill and drain
        for (int k = 0; k < 4; k++) step("fill", 1, mk(32'h100 + 4*k, 0, CAUSE_MISALIGNED_FETCH), 0, 0);
        chk("fill.count_full", 192'(count), 192'(4));
        chk("fill.ready_low",  192'(ready_f), 192'(0));
        for (int k = 0; k < 4; k++) begin
            chk("drain.pc_seq", 192'(pc_d), 192'(32'h100 + 4*k));
            step("drain", 0, idle, 0, 1);
        end
        chk("drain.empty", 192'(valid_d), 192'(0));
        chk("drain.nop",   192'(inst_d),  192'(32'h0000_0013));

        // Wrap-around at steady occupancy 1
        step("wrap0", 1, mk(32'h200, 0, CAUSE_MISALIGNED_FETCH), 0, 0);
        for (int k = 1; k < 10; k++) begin
            chk("wrap.head", 192'(pc_d), 192'(32'h200 + 4*(k-1)));
            step("wrap", 1, mk(32'h200 + 4*k, 0, CAUSE_MISALIGNED_FETCH), 0, 1);
            chk("wrap.count1", 192'(count), 192'(1));
        end
        step("wrap_end", 0, idle, 0, 1);

        // Flush mid-stream
        for (int k = 0; k < 3; k++) step("pre_flush", 1, mk(32'h280 + 4*k, 0, CAUSE_MISALIGNED_FETCH), 0, 0);
        step("flush", 1, mk(32'h300, 0, CAUSE_MISALIGNED_FETCH), 1, 1);
        chk("flush.count", 192'(count), 192'(0));
        chk("flush.valid", 192'(valid_d), 192'(0));
        for (int k = 0; k < 2; k++) begin
            step("post_flush", 0, idle, 0, 1);
            chk("flush.no_0x300", 192'(valid_d && pc_d == 32'h300), 192'(0));
        end

        // Trap fence
        step("trap", 1, mk(32'h400, 1, CAUSE_ILLEGAL_INSTRUCTION), 0, 0);
        chk("trap.ready_drop", 192'(ready_f), 192'(0));
        step("fenced", 1, mk(32'h404, 0, CAUSE_MISALIGNED_FETCH), 0, 0);
        chk("trap.head_valid", 192'(trap_req_d.valid), 192'(1));
        chk("trap.head_cause", 192'(trap_req_d.cause), 192'(CAUSE_ILLEGAL_INSTRUCTION));
        step("trap_drain", 1, mk(32'h408, 0, CAUSE_MISALIGNED_FETCH), 0, 1);
        chk("trap.still_fenced", 192'(ready_f), 192'(0));
        step("trap_flush", 0, idle, 1, 0);
        chk("trap.unfenced", 192'(ready_f), 192'(1));

        // Asynchronous reset between edges
        for (int k = 0; k < 2; k++) step("pre_rst", 1, mk(32'h480 + 4*k, 0, CAUSE_MISALIGNED_FETCH), 0, 0);
        valid_f = 0; ready_d = 0;
        #1 start = 1'b0;
        #1;
        mq.delete(); mfence = 0;
        chk("arst.valid", 192'(valid_d), 192'(0));
        chk("arst.count", 192'(count), 192'(0));
        chk("arst.ready", 192'(ready_f), 192'(1));
        check_outputs("arst");
        #1 start = 1'b1;
        step("arst_enq", 1, mk(32'h500, 0, CAUSE_MISALIGNED_FETCH), 0, 0);
        chk("arst.first_pc", 192'(pc_d), 192'(32'h500));

        // Full with dequeue: no accept in the full cycle
        for (int k = 1; k < 4; k++) step("fill2", 1, mk(32'h500 + 4*k, 0, CAUSE_MISALIGNED_FETCH), 0, 0);
        chk("full.ready_low", 192'(ready_f), 192'(0));
        step("full_deq", 1, mk(32'h600, 0, CAUSE_MISALIGNED_FETCH), 0, 1);
        chk("full.count3", 192'(count), 192'(3));
        chk("full.ready_back", 192'(ready_f), 192'(1));
        step("full_flush", 0, idle, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            bit vf, rd, fl, tr;
            vf = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 24) == 0);
            tr = ($urandom_range(0, 29) == 0);
            step("rand", vf, mk({$urandom_range(0, 32'hFFFF), 2'b00}, tr,
                               trap_cause_t'($urandom_range(0, 3))), fl, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
